// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised Moore pattern detector.
package seq_detect_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      SEARCH = 2'd2,
      MATCH  = 2'd3
   } st_e;

   localparam int SAT_W = 32;

   // Saturating increment on a wide container; callers pass their own ceiling.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                input logic [SAT_W-1:0] max);
      logic [SAT_W-1:0] res;
      if (value >= max) begin
         res = max;
      end else begin
         res = value + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
   import seq_detect_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [SAT_W-1:0] MAX_C = (32'd1 << W) - 32'd1;

   logic [W-1:0]       count_q;
   logic [W-1:0]       count_d;
   logic [SAT_W-1:0]   inc_wide_s;
   logic [SAT_W-W-1:0] unused_hi_s;

   assign inc_wide_s  = sat_inc(SAT_W'(count_q), MAX_C);
   assign unused_hi_s = inc_wide_s[SAT_W-1:W];

   // Next count: clear, saturating increment or hold.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = inc_wide_s[W-1:0];
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector with run-time pattern, overlap mode and a
// saturating match counter; out is a pure decode of the state register.
module seq_detect_moore
   import seq_detect_pkg::*;
#(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             out,
   output logic [CNT_W-1:0] match_count,
   output logic             filled
);

   localparam int               FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FULL_C = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  pat_q,  pat_d;
   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   st_e               state_q, state_d;
   logic [PAT_W-1:0]  hist_n_s;
   logic [FILL_W-1:0] fill_n_s;
   logic              cnt_inc_s;
   logic              cnt_clr_s;

   // Next-state, history, fill level and counter controls.
   always_comb begin
      pat_d     = pat_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      state_d   = state_q;
      cnt_inc_s = 1'b0;
      cnt_clr_s = 1'b0;
      hist_n_s  = {hist_q[PAT_W-2:0], in};
      fill_n_s  = (fill_q == FULL_C) ? FULL_C : fill_q + FILL_W'(1);

      if (load) begin
         pat_d     = pattern;
         hist_d    = '0;
         fill_d    = '0;
         state_d   = IDLE;
         cnt_clr_s = 1'b1;
      end else if (en) begin
         hist_d = hist_n_s;
         if ((fill_n_s == FULL_C) && (hist_n_s == pat_q)) begin
            state_d   = MATCH;
            cnt_inc_s = 1'b1;
            // Non-overlapping mode forces a full refill before the next match.
            fill_d    = overlap ? fill_n_s : '0;
         end else begin
            fill_d  = fill_n_s;
            state_d = (fill_n_s == FULL_C) ? SEARCH : FILL;
         end
      end else begin
         case (state_q)
            MATCH: begin
               if (fill_q == FULL_C) begin
                  state_d = SEARCH;
               end else if (fill_q == '0) begin
                  state_d = IDLE;
               end else begin
                  state_d = FILL;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Pattern, history, fill and state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q   <= PAT_RST;
         hist_q  <= '0;
         fill_q  <= '0;
         state_q <= IDLE;
      end else begin
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         state_q <= state_d;
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (cnt_inc_s),
      .clr  (cnt_clr_s),
      .count(match_count)
   );

   assign out    = (state_q == MATCH);
   assign filled = (fill_q == FULL_C);

endmodule

// File: tb/tb_seq_detect_moore.sv
// Bench for seq_detect_moore: vector table, directed corner cases and random
// stimulus against a bit-queue reference model; a CNT_W=2 copy covers saturation.
module tb_seq_detect_moore;

   localparam int PW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          en, in_b, load, overlap;
   logic [PW-1:0] pattern;
   logic          out_a, filled_a, out_b, filled_b;
   logic [7:0]    cnt_a;
   logic [1:0]    cnt_b;

   int checks = 0;
   int errors = 0;

   // reference model state
   int            m_q[$];
   logic [PW-1:0] m_pat;
   int            m_cnt;
   logic          m_out;

   typedef struct {
      logic          en;
      logic          in;
      logic          load;
      logic [PW-1:0] pat;
      logic          ovl;
      logic          e_out;
      logic          e_filled;
      int            e_cnt;
   } vec_t;
   vec_t tbl[$];

   seq_detect_moore dut (
      .clk(clk), .rst(rst), .en(en), .in(in_b), .load(load), .pattern(pattern),
      .overlap(overlap), .out(out_a), .match_count(cnt_a), .filled(filled_a)
   );

   seq_detect_moore #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .in(in_b), .load(load), .pattern(pattern),
      .overlap(overlap), .out(out_b), .match_count(cnt_b), .filled(filled_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pat = 3'b101;
      m_cnt = 0;
      m_out = 1'b0;
   endtask

   // One clock edge of the reference: keep the last PW accepted bits.
   task automatic model_edge();
      int val;
      m_out = 1'b0;
      if (load) begin
         m_pat = pattern;
         m_q.delete();
         m_cnt = 0;
      end else if (en) begin
         m_q.push_back(int'(in_b));
         if (m_q.size() > PW) void'(m_q.pop_front());
         val = 0;
         foreach (m_q[k]) val = val * 2 + m_q[k];
         if (m_q.size() == PW && val == int'(m_pat)) begin
            m_out = 1'b1;
            m_cnt++;
            if (!overlap) m_q.delete();
         end
      end
   endtask

   task automatic step(input logic e, input logic i, input logic l,
                       input logic [PW-1:0] p, input logic o);
      en = e; in_b = i; load = l; pattern = p; overlap = o;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".out"},      32'(out_a),    32'(m_out));
      chk({tag, ".filled"},   32'(filled_a), 32'(m_q.size() == PW));
      chk({tag, ".cnt"},      32'(cnt_a),    32'(sat(m_cnt, 8)));
      chk({tag, ".sat_out"},  32'(out_b),    32'(m_out));
      chk({tag, ".sat_cnt"},  32'(cnt_b),    32'(sat(m_cnt, 2)));
   endtask

   task automatic add(input logic e, input logic i, input logic l, input logic [PW-1:0] p,
                      input logic o, input logic eo, input logic ef, input int ec);
      tbl.push_back('{e, i, l, p, o, eo, ef, ec});
   endtask

   initial begin
      int pulses;
      rst = 1'b0; en = 1'b0; in_b = 1'b0; load = 1'b0; overlap = 1'b1; pattern = 3'b000;
      model_reset();
      @(negedge clk);
      chk("rst.out",    32'(out_a),     32'd0);
      chk("rst.cnt",    32'(cnt_a),     32'd0);
      chk("rst.filled", 32'(filled_a),  32'd0);
      chk("rst.pat",    32'(dut.pat_q), 32'd5);
      rst = 1'b1;

      // overlap stream 1,0,1,0,1
      add(1,1,0,3'b000,1, 0,0,0); add(1,0,0,3'b000,1, 0,0,0); add(1,1,0,3'b000,1, 1,1,1);
      add(1,0,0,3'b000,1, 0,1,1); add(1,1,0,3'b000,1, 1,1,2);
      // reload 101, non-overlap stream
      add(1,1,1,3'b101,0, 0,0,0);
      add(1,1,0,3'b000,0, 0,0,0); add(1,0,0,3'b000,0, 0,0,0); add(1,1,0,3'b000,0, 1,0,1);
      add(1,0,0,3'b000,0, 0,0,1); add(1,1,0,3'b000,0, 0,0,1); add(0,1,0,3'b000,0, 0,0,1);
      // load 111 with a discarded 1, then 1,1,1,1
      add(1,1,1,3'b111,1, 0,0,0);
      add(1,1,0,3'b000,1, 0,0,0); add(1,1,0,3'b000,1, 0,0,0); add(1,1,0,3'b000,1, 1,1,1);
      add(1,1,0,3'b000,1, 1,1,2); add(0,0,0,3'b000,1, 0,1,2);
      // enable gaps with pattern 101
      add(1,0,1,3'b101,1, 0,0,0);
      add(1,1,0,3'b000,1, 0,0,0); add(0,0,0,3'b000,1, 0,0,0); add(0,0,0,3'b000,1, 0,0,0);
      add(1,0,0,3'b000,1, 0,0,0); add(1,1,0,3'b000,1, 1,1,1); add(0,0,0,3'b000,1, 0,1,1);

      foreach (tbl[n]) begin
         step(tbl[n].en, tbl[n].in, tbl[n].load, tbl[n].pat, tbl[n].ovl);
         chk($sformatf("vec%0d.out", n),    32'(out_a),    32'(tbl[n].e_out));
         chk($sformatf("vec%0d.filled", n), 32'(filled_a), 32'(tbl[n].e_filled));
         chk($sformatf("vec%0d.cnt", n),    32'(cnt_a),    32'(tbl[n].e_cnt));
      end

      // reset mid-pattern discards partial progress
      step(1,1,0,3'b000,1);
      step(1,0,0,3'b000,1);
      rst = 1'b0;
      #2;
      model_reset();
      chk("midrst.out", 32'(out_a),     32'd0);
      chk("midrst.cnt", 32'(cnt_a),     32'd0);
      chk("midrst.pat", 32'(dut.pat_q), 32'd5);
      #1 rst = 1'b1;
      step(1,1,0,3'b000,1);
      chk("midrst.fill", 32'(dut.fill_q), 32'd1);
      chk_model("midrst");

      // saturation: 5 overlapping matches of 101
      step(0,0,1,3'b101,1);
      pulses = 0;
      for (int k = 0; k < 11; k++) begin
         step(1, logic'((k % 2) == 0), 0, 3'b000, 1);
         chk_model($sformatf("sat%0d", k));
         if (out_b) pulses++;
      end
      chk("sat.pulses", 32'(pulses), 32'd5);
      chk("sat.cnt2",   32'(cnt_b),  32'd3);
      chk("sat.cnt8",   32'(cnt_a),  32'd5);

      // random stimulus against the model
      for (int k = 0; k < 3000; k++) begin
         step(logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 99) < 3), PW'($urandom_range(0, 7)),
              logic'($urandom_range(0, 3) != 0));
         chk_model("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_detect_moore.md
# seq_detect_moore

Parametrised Moore-style serial pattern detector, the successor to the fixed "101" detector in the FSM exercise set. It watches a 1-bit serial input qualified by an enable and asserts a registered match flag, whose value depends only on state. Pattern, overlap mode and a saturating match counter are all run-time controllable. It sits between a serial bit source and any consumer of match pulses or match counts.

## Interface
- `PAT_W`, default 3: pattern length in bits, legal range 2..16.
- `PAT_RST`, default `3'b101` (width `PAT_W`): pattern loaded at reset.
- `CNT_W`, default 8: width of the match counter.

Ports:
- `clk`, input, 1: single system clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: when high, `in` is a valid sample this cycle.
- `in`, input, 1: serial data bit.
- `load`, input, 1: capture `pattern` and restart the search.
- `pattern`, input, `PAT_W`: new pattern; the MSB is the first bit expected.
- `overlap`, input, 1: 1 = overlapping matches allowed; 0 = non-overlapping.
- `out`, output, 1: high exactly while the FSM is in MATCH.
- `match_count`, output, `CNT_W`: number of matches since reset or the last load; saturates at all-ones.
- `filled`, output, 1: high when the history holds `PAT_W` valid bits.

## Operation
- Internal registers:
  - `pat_q` (`PAT_W`)
  - `hist` (`PAT_W`), shifted left with the newest bit in the LSB
  - `fill` (0..`PAT_W`)
  - `state` (2 bits)
  - `match_count`
- FSM states:
  - IDLE: after reset or load, no samples yet.
  - FILL: 0 < `fill` < `PAT_W`.
  - SEARCH: `fill` == `PAT_W`, last sample did not match.
  - MATCH: last accepted sample completed the pattern.
- Accepted sample (`en`=1, `load`=0):
  - `hist_n` = {`hist`[`PAT_W`-2:0], `in`}
  - `fill_n` = min(`fill`+1, `PAT_W`)
- Match condition: `fill_n` == `PAT_W` and `hist_n` == `pat_q`.
  - Next state is MATCH.
  - `match_count` increments unless it is already all-ones.
  - If `overlap`=0, `fill` is set to 0 instead of `fill_n`, so the next match needs `PAT_W` fresh bits.
- No match on an accepted sample: next state is FILL if `fill_n` < `PAT_W`, otherwise SEARCH.
- MATCH lasts one cycle when `en`=0 that cycle. It exits to SEARCH if `fill`==`PAT_W`, otherwise to FILL, or to IDLE if `fill`==0.
- If `en`=1 in MATCH, the sample is processed normally, so back-to-back MATCH is legal.
- `en`=0 outside MATCH: `hist`, `fill`, `state` and the counter hold.
- `load`=1, which has priority over `en`:
  - `pat_q` <= `pattern`
  - `hist`, `fill` and `match_count` cleared
  - state <= IDLE
  - The sample presented that cycle is discarded.
- `overlap` is sampled on the match cycle only; changing it mid-stream is legal.
- `filled` = (`fill` == `PAT_W`), combinational from registers.

## Timing
- Reset (`rst`=0, asynchronous):
  - state = IDLE, `out`=0, `match_count`=0, `filled`=0
  - `hist`=0, `fill`=0, `pat_q`=`PAT_RST`
- The release of `rst` is synchronised externally; the first sample is accepted on the first rising edge with `rst`=1.
- Latency: `out` rises in the cycle after the edge that samples the final pattern bit. It is a 1-cycle pulse per match, and multi-cycle only for consecutive matches.
- `match_count` updates on the same edge that enters MATCH.
- `load` takes effect on the next edge; `out` is 0 the cycle after any load.
- Reset mid-pattern discards all partial progress.
- The counter at all-ones stays at all-ones; `out` still pulses.

## Structure
- Package `seq_detect_pkg`:
  - state enum `st_e` {IDLE=2'd0, FILL=2'd1, SEARCH=2'd2, MATCH=2'd3}
  - helper function `sat_inc` for the counter.
- Single module; the counter is factored as sub-module `sat_counter` (parameter `W`; inputs `inc`, `clr`).
- Next-state logic in one combinational block; all registers in one sequential block with asynchronous reset.

## Test plan
- Reset check: hold `rst`=0, then release -> `out`=0, `match_count`=0, `filled`=0, `pat_q`=`3'b101`.
- Overlap mode: `overlap`=1, `en`=1, `in` = 1,0,1,0,1 -> `out` pulses one cycle after the 3rd and 5th samples; `match_count`=2.
- Non-overlap mode: same stream with `overlap`=0 -> single pulse after the 3rd sample; `match_count`=1; `filled`=0 in the cycle after the match.
- Load and back-to-back matches: load `pattern`=`3'b111` with `overlap`=1, then `in` = 1,1,1,1 -> `out` high for two consecutive cycles; `match_count`=2. A sample presented with `load` is ignored.
- Enable gaps: `in` 1 (`en`=1); then `in` 0,0 with `en`=0; then `in` 0,1 with `en`=1 -> one match; `out` is not asserted during the gaps.
- Reset mid-pattern and saturation:
  - Feed 1,0, then pulse `rst` low, then feed 1 -> no match; `fill`=1.
  - With `CNT_W`=2, 5 matches -> `match_count`=3 and `out` pulses 5 times.
